// File: rtl/memory_sequencer_pkg.sv
// Shared definitions for the memory sequencer: FSM state encodings, default widths
// and the address range helper.
package memory_sequencer_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    // True when any MAR bit above the RAM address width is set.
    function automatic logic addr_out_of_range(input logic [31:0] addr, input int unsigned aw);
        logic oob;
        if (aw >= 32'd32) begin
            oob = 1'b0;
        end else begin
            oob = ((addr >> aw) != 32'd0);
        end
        return oob;
    endfunction

endpackage

// File: rtl/memory_sequencer_strobe_edge.sv
// Rising-edge detector for a control-unit strobe. The registered level resets to 1 so
// that a strobe held high through reset is not seen as a new request.
module strobe_edge (
    input  logic clock,
    input  logic clear,
    input  logic level,
    output logic rise
);

    logic level_r;

    // Previous-cycle level of the strobe.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            level_r <= 1'b1;
        end else begin
            level_r <= level;
        end
    end

    assign rise = level & ~level_r;

endmodule

// File: rtl/memory_sequencer.sv
// Converts control-unit Read/Write strobes into timed synchronous-RAM cycles with
// configurable wait states, returning captured read data and a one-cycle done pulse.
module memory_sequencer
    import memory_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              Read,
    input  logic              Write,
    input  logic              Run,
    input  logic [31:0]       addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_re,
    output logic              ram_we,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              busy,
    output logic              err
);

    localparam logic [2:0] RD_CNT = 3'(RD_LAT);
    localparam logic [2:0] WR_CNT = 3'(WR_LAT);

    state_t            state_r, state_s;
    logic [2:0]        cnt_r, cnt_s;
    logic              rd_req_s, wr_req_s, oob_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] wdata_s, rd_data_s;
    logic              re_s, we_s, done_s, err_s;

    strobe_edge u_read_edge (
        .clock (clock),
        .clear (clear),
        .level (Read),
        .rise  (rd_req_s)
    );

    strobe_edge u_write_edge (
        .clock (clock),
        .clear (clear),
        .level (Write),
        .rise  (wr_req_s)
    );

    assign oob_s = addr_out_of_range(addr_in, ADDR_W);

    // Next-state, wait-state counter and next output values.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        addr_s    = ram_addr;
        wdata_s   = ram_wdata;
        rd_data_s = rd_data;
        re_s      = 1'b0;
        we_s      = 1'b0;
        done_s    = 1'b0;
        err_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (Run && wr_req_s) begin
                    state_s = S_WRITE;
                    cnt_s   = WR_CNT;
                    addr_s  = addr_in[ADDR_W-1:0];
                    wdata_s = wdata_in;
                    we_s    = 1'b1;
                    err_s   = rd_req_s | oob_s;
                end else if (Run && rd_req_s) begin
                    state_s = S_READ;
                    cnt_s   = RD_CNT;
                    addr_s  = addr_in[ADDR_W-1:0];
                    re_s    = 1'b1;
                    err_s   = oob_s;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_READ: begin
                err_s = Run & (rd_req_s | wr_req_s);
                if (cnt_r == 3'd0) begin
                    state_s   = S_IDLE;
                    rd_data_s = ram_rdata;
                    done_s    = 1'b1;
                end else begin
                    cnt_s = cnt_r - 3'd1;
                end
            end
            S_WRITE: begin
                err_s = Run & (rd_req_s | wr_req_s);
                if (cnt_r == 3'd0) begin
                    state_s = S_IDLE;
                    done_s  = 1'b1;
                end else begin
                    // Enable covers exactly WR_LAT cycles; the final count cycle is idle.
                    cnt_s = cnt_r - 3'd1;
                    we_s  = (cnt_r != 3'd1);
                end
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = 3'd0;
            end
        endcase
    end

    // FSM state and wait-state counter.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r <= S_IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Registered outputs toward the RAM and the control unit.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_re    <= 1'b0;
            ram_we    <= 1'b0;
            rd_data   <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            ram_addr  <= addr_s;
            ram_wdata <= wdata_s;
            ram_re    <= re_s;
            ram_we    <= we_s;
            rd_data   <= rd_data_s;
            done      <= done_s;
            busy      <= (state_s != S_IDLE);
            err       <= err_s;
        end
    end

endmodule

// File: tb/tb_memory_sequencer.sv
// Directed self-checking bench for memory_sequencer with a behavioural synchronous RAM
// whose read data appears two clocks after ram_re.
module tb_memory_sequencer;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              clear;
    logic              Read, Write, Run;
    logic [31:0]       addr_in;
    logic [DATA_W-1:0] wdata_in;
    logic [DATA_W-1:0] ram_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_re, ram_we;
    logic [DATA_W-1:0] rd_data;
    logic              done, busy, err;

    logic [DATA_W-1:0] mem [0:511];
    logic [DATA_W-1:0] rd_stage;

    int n_tests = 0;
    int n_fail  = 0;

    memory_sequencer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (2),
        .WR_LAT (1)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .Read      (Read),
        .Write     (Write),
        .Run       (Run),
        .addr_in   (addr_in),
        .wdata_in  (wdata_in),
        .ram_rdata (ram_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_re    (ram_re),
        .ram_we    (ram_we),
        .rd_data   (rd_data),
        .done      (done),
        .busy      (busy),
        .err       (err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) rd_stage <= mem[ram_addr];
        ram_rdata <= rd_stage;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        mem[9'h1A2] = 32'hDEADBEEF;
        rd_stage  = 32'h0;
        ram_rdata = 32'h0;
        clear = 1'b1; Read = 1'b0; Write = 1'b0; Run = 1'b1;
        addr_in = 32'h0; wdata_in = 32'h0;

        // Reset state
        tick();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_ram_re", {63'd0, ram_re}, 64'd0);
        chk("rst_ram_we", {63'd0, ram_we}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_rd_data", {32'd0, rd_data}, 64'd0);
        chk("rst_ram_addr", {55'd0, ram_addr}, 64'd0);
        clear = 1'b0;
        tick(); tick();

        // Read of 0x1A2 with two wait states
        addr_in = 32'h0000_01A2; Read = 1'b1;
        tick();
        chk("rd_re_e0", {63'd0, ram_re}, 64'd1);
        chk("rd_busy_e0", {63'd0, busy}, 64'd1);
        chk("rd_addr_e0", {55'd0, ram_addr}, 64'h1A2);
        chk("rd_err_e0", {63'd0, err}, 64'd0);
        Read = 1'b0;
        tick();
        chk("rd_re_e1", {63'd0, ram_re}, 64'd0);
        chk("rd_busy_e1", {63'd0, busy}, 64'd1);
        tick();
        chk("rd_busy_e2", {63'd0, busy}, 64'd1);
        chk("rd_done_e2", {63'd0, done}, 64'd0);
        tick();
        chk("rd_done_e3", {63'd0, done}, 64'd1);
        chk("rd_data_e3", {32'd0, rd_data}, 64'hDEADBEEF);
        chk("rd_busy_e3", {63'd0, busy}, 64'd0);
        tick();
        chk("rd_done_e4", {63'd0, done}, 64'd0);
        chk("rd_hold_e4", {32'd0, rd_data}, 64'hDEADBEEF);

        // Write 0x12345678 to 0x05, then read it back
        addr_in = 32'h0000_0005; wdata_in = 32'h1234_5678; Write = 1'b1;
        tick();
        chk("wr_we_e0", {63'd0, ram_we}, 64'd1);
        chk("wr_wdata_e0", {32'd0, ram_wdata}, 64'h12345678);
        chk("wr_busy_e0", {63'd0, busy}, 64'd1);
        Write = 1'b0;
        tick();
        chk("wr_we_e1", {63'd0, ram_we}, 64'd0);
        chk("wr_done_e1", {63'd0, done}, 64'd0);
        tick();
        chk("wr_done_e2", {63'd0, done}, 64'd1);
        chk("wr_busy_e2", {63'd0, busy}, 64'd0);
        Read = 1'b1;
        tick();
        Read = 1'b0;
        tick(); tick(); tick();
        chk("rb_done", {63'd0, done}, 64'd1);
        chk("rb_data", {32'd0, rd_data}, 64'h12345678);

        // Write request while a read is in flight is dropped
        tick();
        addr_in = 32'h0000_0010; Read = 1'b1;
        tick();
        chk("col_err_e0", {63'd0, err}, 64'd0);
        Read = 1'b0; Write = 1'b1; wdata_in = 32'h5555_AAAA;
        tick();
        chk("col_err_e1", {63'd0, err}, 64'd1);
        chk("col_we_e1", {63'd0, ram_we}, 64'd0);
        Write = 1'b0;
        tick();
        chk("col_err_e2", {63'd0, err}, 64'd0);
        chk("col_we_e2", {63'd0, ram_we}, 64'd0);
        tick();
        chk("col_done_e3", {63'd0, done}, 64'd1);
        chk("col_mem10", {32'd0, mem[9'h010]}, 64'd0);

        // Simultaneous Read/Write, out-of-range address: write wins on truncated address
        tick();
        addr_in = 32'h0000_0200; wdata_in = 32'hCAFE_F00D; Read = 1'b1; Write = 1'b1;
        tick();
        chk("both_err", {63'd0, err}, 64'd1);
        chk("both_we", {63'd0, ram_we}, 64'd1);
        chk("both_re", {63'd0, ram_re}, 64'd0);
        chk("both_addr", {55'd0, ram_addr}, 64'd0);
        Read = 1'b0; Write = 1'b0;
        tick();
        chk("both_err_e1", {63'd0, err}, 64'd0);
        tick();
        chk("both_done", {63'd0, done}, 64'd1);
        chk("both_mem0", {32'd0, mem[9'h000]}, 64'hCAFEF00D);

        // Asynchronous clear mid-read with Read held high
        tick();
        addr_in = 32'h0000_01A2; Read = 1'b1;
        tick();
        chk("clr_re_pre", {63'd0, ram_re}, 64'd1);
        clear = 1'b1;
        #1;
        chk("clr_re_async", {63'd0, ram_re}, 64'd0);
        chk("clr_busy_async", {63'd0, busy}, 64'd0);
        chk("clr_addr_async", {55'd0, ram_addr}, 64'd0);
        chk("clr_rd_data_async", {32'd0, rd_data}, 64'd0);
        tick();
        clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("clr_post_done", {63'd0, done}, 64'd0);
            chk("clr_post_busy", {63'd0, busy}, 64'd0);
        end
        Read = 1'b0;
        tick();

        // Halted: rising Read ignored silently
        Run = 1'b0; Read = 1'b1;
        tick();
        chk("halt_re", {63'd0, ram_re}, 64'd0);
        chk("halt_err", {63'd0, err}, 64'd0);
        chk("halt_busy", {63'd0, busy}, 64'd0);
        Read = 1'b0;
        tick();

        // Run dropped mid-write: write still completes
        Run = 1'b1; Write = 1'b1; addr_in = 32'h0000_0007; wdata_in = 32'h0BAD_F00D;
        tick();
        chk("runoff_we", {63'd0, ram_we}, 64'd1);
        Run = 1'b0; Write = 1'b0;
        tick();
        chk("runoff_busy", {63'd0, busy}, 64'd1);
        tick();
        chk("runoff_done", {63'd0, done}, 64'd1);
        chk("runoff_mem7", {32'd0, mem[9'h007]}, 64'h0BADF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
